pc_flow_ctrl: RTL and testbench
===============================

# pc_flow_ctrl

Control-flow sequencer for the pipelined femtoRV32 core. Owns the select line of the next-PC mux and the PC, IF/ID and ID/EX enables and flushes. Arbitrates the single-ported unified memory between instruction fetch and MEM-stage data accesses. Sequences redirect flushes and EBREAK halt/resume. Sits between the hazard-detection unit, the EX-stage branch/jump resolution logic and the PC register.

## Interface
Parameters:
- FLUSH_CYCLES, 2: total cycles (redirect cycle included) during which younger-instruction control inputs are ignored and flushes held; legal range 1..7.
- HALT_ON_EBREAK, 1: 1 = EBREAK halts the core; 0 = EBREAK is treated as ECALL.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- branch_taken  in  1  EX: taken conditional branch or JAL.
- jalr_ex  in  1  EX: JALR.
- ecall_ex  in  1  EX: ECALL.
- ebreak_ex  in  1  EX: EBREAK.
- load_use  in  1  load-use hazard from the hazard-detection unit.
- mem_req_ex  in  1  MEM-stage load/store needs the memory port this cycle.
- resume  in  1  single-cycle pulse that leaves HALT.
- pc_sel_src  out  2  next-PC select: 00 PC+4, 01 branch/JAL target, 10 JALR target, 11 trap vector.
- pc_en  out  1  PC register load enable.
- if_id_en  out  1  IF/ID register enable.
- if_id_flush  out  1  load bubble into IF/ID.
- id_ex_flush  out  1  load bubble into ID/EX.
- mem_grant_data  out  1  memory port given to data (1) or to fetch (0).
- halted  out  1  core is in HALT.

## Operation
- States: RUN, FLUSH, HALT. 3-bit flush counter cnt.
- Decoded EX inputs are valid only in RUN. In FLUSH and HALT they come from squashed instructions and are ignored.
- RUN redirect priority: ebreak (HALT_ON_EBREAK=1) > ecall/ebreak-as-ecall > jalr_ex > branch_taken.
  - ECALL: pc_sel_src=11.
  - JALR: pc_sel_src=10.
  - Branch/JAL: pc_sel_src=01.
  - On any of these redirects: pc_en=1, if_id_flush=1, id_ex_flush=1, if_id_en=1, cnt<=FLUSH_CYCLES-1. Next state is FLUSH if FLUSH_CYCLES>1, otherwise RUN.
- RUN, ebreak with HALT_ON_EBREAK=1: pc_en=0, if_id_en=0, if_id_flush=1, id_ex_flush=1, next state HALT.
- FLUSH:
  - pc_sel_src=00.
  - if_id_flush=1 and id_ex_flush=1 held.
  - cnt decrements each cycle. At cnt==1, next state is RUN.
  - pc_en follows the stall rules below.
- HALT:
  - pc_en=0, if_id_en=0, id_ex_flush=1, halted=1, pc_sel_src=00.
  - resume=1 moves to RUN next cycle. PC resumes at the held value (the instruction after EBREAK).
- Stall rules, applied when no redirect is issued this cycle:
  - mem_req_ex=1: mem_grant_data=1, pc_en=0, if_id_en=0, id_ex_flush=1.
  - Else load_use=1 in RUN: pc_en=0, if_id_en=0, id_ex_flush=1.
  - Else: pc_en=1, if_id_en=1, no flushes (RUN).
- Redirect together with mem_req_ex: mem_grant_data=1. The redirect still wins for pc_en=1 and pc_sel_src, since the fetch is discarded anyway.
- Redirect together with load_use: the redirect wins and load_use is ignored.
- mem_grant_data equals mem_req_ex in every state.

## Timing
- Outputs are combinational from the current state and inputs. State, cnt and halted are registered.
- Redirect effect: PC holds the target at the next edge. The first target instruction is in IF/ID one cycle later.
- Reset (rst_n=0), any state, mid-flush or mid-halt:
  - State=RUN, cnt=0, halted=0.
  - pc_en=0, if_id_en=0, pc_sel_src=00, if_id_flush=1, id_ex_flush=1, mem_grant_data=0.
  - After release, the first edge loads PC+4 normally.
- resume arriving outside HALT is ignored. resume and reset together: reset wins.
- halted rises the cycle after EBREAK is seen in EX and falls the cycle after resume.

## Test plan
- Reset mid-FLUSH: assert rst_n=0 while cnt=1 -> immediately pc_en=0, both flushes=1. After release: RUN, pc_en=1, pc_sel_src=00.
- Taken branch, FLUSH_CYCLES=2: branch_taken=1 in cycle n -> pc_sel_src=01, pc_en=1, flushes=1 in n. branch_taken=1 and jalr_ex=1 in n+1 are ignored, with flushes=1 and pc_sel_src=00. RUN in n+2.
- Simultaneous jalr_ex=1 and branch_taken=1 -> pc_sel_src=10. Simultaneous ecall_ex=1 and jalr_ex=1 -> pc_sel_src=11.
- mem_req_ex=1 and load_use=1 for 2 cycles -> mem_grant_data=1, pc_en=0, if_id_en=0, id_ex_flush=1 both cycles. mem_req_ex=1 with branch_taken=1 -> mem_grant_data=1, pc_en=1, pc_sel_src=01.
- EBREAK with HALT_ON_EBREAK=1 -> HALT. halted=1 and pc_en=0 for 10 cycles while branch_taken toggles. resume pulse -> RUN next cycle, halted=0, pc_en=1. With HALT_ON_EBREAK=0 -> pc_sel_src=11 and no halt.

Source files
------------

// File: rtl/pc_flow_ctrl.sv
// pc_flow_ctrl: control-flow sequencer for the pipelined femtoRV32 core.
// Drives the next-PC mux select, PC / IF/ID / ID/EX enables and flushes,
// arbitrates the unified memory port between fetch and MEM-stage data,
// and sequences redirect flushes and EBREAK halt/resume.
module pc_flow_ctrl #(
    parameter int FLUSH_CYCLES   = 2,     // 1..7, redirect cycle included
    parameter bit HALT_ON_EBREAK = 1'b1   // 0: EBREAK behaves as ECALL
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       branch_taken,
    input  logic       jalr_ex,
    input  logic       ecall_ex,
    input  logic       ebreak_ex,
    input  logic       load_use,
    input  logic       mem_req_ex,
    input  logic       resume,
    output logic [1:0] pc_sel_src,
    output logic       pc_en,
    output logic       if_id_en,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic       mem_grant_data,
    output logic       halted
);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        FLUSH = 2'b01,
        HALT  = 2'b10
    } state_t;

    // Next-PC mux encodings
    localparam logic [1:0] SEL_PC4  = 2'b00;
    localparam logic [1:0] SEL_BR   = 2'b01;
    localparam logic [1:0] SEL_JALR = 2'b10;
    localparam logic [1:0] SEL_TRAP = 2'b11;

    localparam logic [2:0] FLUSH_INIT  = 3'(FLUSH_CYCLES - 1);
    localparam bit         FLUSH_MULTI = (FLUSH_CYCLES > 1);

    state_t     state, state_nxt;
    logic [2:0] cnt, cnt_nxt;

    // Decoded EX-stage control-flow requests (only meaningful in RUN)
    logic ebreak_halt;
    logic trap_req;
    logic redirect;

    always_comb begin
        ebreak_halt = HALT_ON_EBREAK && ebreak_ex;
        trap_req    = ecall_ex || (!HALT_ON_EBREAK && ebreak_ex);
        redirect    = trap_req || jalr_ex || branch_taken;
    end

    // State, flush counter and halted flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RUN;
            cnt    <= '0;
            halted <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            halted <= (state_nxt == HALT);
        end
    end

    // Next-state and flush-counter sequencing
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            RUN: begin
                if (ebreak_halt) begin
                    state_nxt = HALT;
                end else if (redirect) begin
                    cnt_nxt   = FLUSH_INIT;
                    state_nxt = FLUSH_MULTI ? FLUSH : RUN;
                end
            end
            FLUSH: begin
                cnt_nxt = cnt - 3'd1;
                // cnt==0 cannot occur here; treat it as end of flush for safety
                if (cnt <= 3'd1) begin
                    cnt_nxt   = '0;
                    state_nxt = RUN;
                end
            end
            HALT: begin
                if (resume) state_nxt = RUN;
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Pipeline control outputs from current state and inputs
    always_comb begin
        pc_sel_src     = SEL_PC4;
        pc_en          = 1'b0;
        if_id_en       = 1'b0;
        if_id_flush    = 1'b1;
        id_ex_flush    = 1'b1;
        mem_grant_data = 1'b0;
        if (rst_n) begin
            mem_grant_data = mem_req_ex;
            if_id_flush    = 1'b0;
            id_ex_flush    = 1'b0;
            unique case (state)
                RUN: begin
                    if (ebreak_halt) begin
                        // Freeze PC on the instruction after EBREAK, drain younger ones
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (redirect) begin
                        // Redirect wins over stalls: the fetch is discarded anyway
                        if (trap_req)     pc_sel_src = SEL_TRAP;
                        else if (jalr_ex) pc_sel_src = SEL_JALR;
                        else              pc_sel_src = SEL_BR;
                        pc_en       = 1'b1;
                        if_id_en    = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (mem_req_ex || load_use) begin
                        id_ex_flush = 1'b1;
                    end else begin
                        pc_en    = 1'b1;
                        if_id_en = 1'b1;
                    end
                end
                FLUSH: begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    if (!mem_req_ex) begin
                        pc_en    = 1'b1;
                        if_id_en = 1'b1;
                    end
                end
                HALT: begin
                    id_ex_flush = 1'b1;
                end
                default: begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_flow_ctrl.sv
// Directed self-checking bench for pc_flow_ctrl. Two instances share the
// inputs: default parameters, and HALT_ON_EBREAK=0.
module tb_pc_flow_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       branch_taken, jalr_ex, ecall_ex, ebreak_ex;
    logic       load_use, mem_req_ex, resume;

    logic [1:0] pc_sel_src,  pc_sel_src_e;
    logic       pc_en,       pc_en_e;
    logic       if_id_en,    if_id_en_e;
    logic       if_id_flush, if_id_flush_e;
    logic       id_ex_flush, id_ex_flush_e;
    logic       mem_grant_data, mem_grant_data_e;
    logic       halted,      halted_e;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Output bundles: {pc_sel_src, pc_en, if_id_en, if_id_flush, id_ex_flush, mem_grant_data, halted}
    logic [7:0] obs, obs_e;
    assign obs   = {pc_sel_src, pc_en, if_id_en, if_id_flush, id_ex_flush, mem_grant_data, halted};
    assign obs_e = {pc_sel_src_e, pc_en_e, if_id_en_e, if_id_flush_e, id_ex_flush_e, mem_grant_data_e, halted_e};

    pc_flow_ctrl #(.FLUSH_CYCLES(2), .HALT_ON_EBREAK(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .branch_taken(branch_taken), .jalr_ex(jalr_ex), .ecall_ex(ecall_ex),
        .ebreak_ex(ebreak_ex), .load_use(load_use), .mem_req_ex(mem_req_ex),
        .resume(resume),
        .pc_sel_src(pc_sel_src), .pc_en(pc_en), .if_id_en(if_id_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .mem_grant_data(mem_grant_data), .halted(halted)
    );

    pc_flow_ctrl #(.FLUSH_CYCLES(2), .HALT_ON_EBREAK(1'b0)) dut_e (
        .clk(clk), .rst_n(rst_n),
        .branch_taken(branch_taken), .jalr_ex(jalr_ex), .ecall_ex(ecall_ex),
        .ebreak_ex(ebreak_ex), .load_use(load_use), .mem_req_ex(mem_req_ex),
        .resume(resume),
        .pc_sel_src(pc_sel_src_e), .pc_en(pc_en_e), .if_id_en(if_id_en_e),
        .if_id_flush(if_id_flush_e), .id_ex_flush(id_ex_flush_e),
        .mem_grant_data(mem_grant_data_e), .halted(halted_e)
    );

    // Expected bundles
    localparam logic [7:0] E_RESET  = 8'b00_0_0_1_1_0_0;
    localparam logic [7:0] E_RUN    = 8'b00_1_1_0_0_0_0;
    localparam logic [7:0] E_BR     = 8'b01_1_1_1_1_0_0;
    localparam logic [7:0] E_JALR   = 8'b10_1_1_1_1_0_0;
    localparam logic [7:0] E_TRAP   = 8'b11_1_1_1_1_0_0;
    localparam logic [7:0] E_FLUSH  = 8'b00_1_1_1_1_0_0;
    localparam logic [7:0] E_MSTALL = 8'b00_0_0_0_1_1_0;
    localparam logic [7:0] E_LSTALL = 8'b00_0_0_0_1_0_0;
    localparam logic [7:0] E_MBR    = 8'b01_1_1_1_1_1_0;
    localparam logic [7:0] E_MFLUSH = 8'b00_0_0_1_1_1_0;
    localparam logic [7:0] E_EBRK   = 8'b00_0_0_1_1_0_0;
    localparam logic [7:0] E_HALT   = 8'b00_0_0_0_1_0_1;

    // Drive all control inputs (applied on the falling edge, away from the active edge)
    task automatic drive(input logic br, input logic jr, input logic ec, input logic eb,
                         input logic lu, input logic mr, input logic rs);
        branch_taken = br; jalr_ex = jr; ecall_ex = ec; ebreak_ex = eb;
        load_use = lu; mem_req_ex = mr; resume = rs;
        #1;
    endtask

    // Advance to the next falling edge, passing one rising edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 1, 0);
        n_checks++;
        if (obs !== E_RESET) begin
            n_fail++; $display("FAIL reset_outputs: got %b expected %b", obs, E_RESET);
        end
        tick();
        drive(1, 1, 1, 1, 1, 1, 1);
        n_checks++;
        if (obs !== E_RESET) begin
            n_fail++; $display("FAIL reset_inputs_ignored: got %b expected %b", obs, E_RESET);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (obs !== E_RUN) begin
            n_fail++; $display("FAIL reset_release_run: got %b expected %b", obs, E_RUN);
        end
        tick();
        n_checks++;
        if (obs !== E_RUN) begin
            n_fail++; $display("FAIL run_after_reset: got %b expected %b", obs, E_RUN);
        end
    endtask

    task automatic test_branch();
        drive(1, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (obs !== E_BR) begin
            n_fail++; $display("FAIL branch_redirect: got %b expected %b", obs, E_BR);
        end
        tick();
        drive(1, 1, 0, 0, 1, 0, 0);
        n_checks++;
        if (obs !== E_FLUSH) begin
            n_fail++; $display("FAIL branch_flush_ignores_ex: got %b expected %b", obs, E_FLUSH);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (obs !== E_RUN) begin
            n_fail++; $display("FAIL branch_back_to_run: got %b expected %b", obs, E_RUN);
        end
    endtask

    task automatic test_priority();
        drive(1, 1, 0, 0, 1, 0, 0);
        n_checks++;
        if (obs !== E_JALR) begin
            n_fail++; $display("FAIL prio_jalr_over_branch: got %b expected %b", obs, E_JALR);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (obs !== E_FLUSH) begin
            n_fail++; $display("FAIL jalr_flush: got %b expected %b", obs, E_FLUSH);
        end
        tick();
        drive(0, 1, 1, 0, 0, 0, 0);
        n_checks++;
        if (obs !== E_TRAP) begin
            n_fail++; $display("FAIL prio_ecall_over_jalr: got %b expected %b", obs, E_TRAP);
        end
        n_checks++;
        if (obs_e !== E_TRAP) begin
            n_fail++; $display("FAIL prio_ecall_noebrk_inst: got %b expected %b", obs_e, E_TRAP);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        n_checks++;
        if (obs !== E_RUN) begin
            n_fail++; $display("FAIL ecall_back_to_run: got %b expected %b", obs, E_RUN);
        end
    endtask

    task automatic test_stall();
        drive(0, 0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs !== E_MSTALL) begin
                n_fail++; $display("FAIL mem_lu_stall_c%0d: got %b expected %b", i, obs, E_MSTALL);
            end
            tick();
        end
        drive(0, 0, 0, 0, 1, 0, 0);
        n_checks++;
        if (obs !== E_LSTALL) begin
            n_fail++; $display("FAIL load_use_stall: got %b expected %b", obs, E_LSTALL);
        end
        tick();
        drive(1, 0, 0, 0, 1, 1, 0);
        n_checks++;
        if (obs !== E_MBR) begin
            n_fail++; $display("FAIL mem_with_branch: got %b expected %b", obs, E_MBR);
        end
        tick();
        drive(0, 0, 0, 0, 0, 1, 0);
        n_checks++;
        if (obs !== E_MFLUSH) begin
            n_fail++; $display("FAIL mem_during_flush: got %b expected %b", obs, E_MFLUSH);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (obs !== E_RUN) begin
            n_fail++; $display("FAIL stall_back_to_run: got %b expected %b", obs, E_RUN);
        end
    endtask

    task automatic test_halt();
        // resume outside HALT has no effect
        drive(0, 0, 0, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (obs !== E_RUN) begin
            n_fail++; $display("FAIL resume_outside_halt: got %b expected %b", obs, E_RUN);
        end
        drive(1, 0, 0, 1, 0, 0, 0);
        n_checks++;
        if (obs !== E_EBRK) begin
            n_fail++; $display("FAIL ebreak_entry: got %b expected %b", obs, E_EBRK);
        end
        n_checks++;
        if (obs_e !== E_TRAP) begin
            n_fail++; $display("FAIL ebreak_as_ecall: got %b expected %b", obs_e, E_TRAP);
        end
        tick();
        for (int i = 0; i < 10; i++) begin
            drive((i % 2) == 0, 0, 0, 0, 0, 0, 0);
            n_checks++;
            if (obs !== E_HALT) begin
                n_fail++; $display("FAIL halt_hold_c%0d: got %b expected %b", i, obs, E_HALT);
            end
            n_checks++;
            if (halted_e !== 1'b0) begin
                n_fail++; $display("FAIL no_halt_inst_c%0d: got %b expected 0", i, halted_e);
            end
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 1);
        n_checks++;
        if (obs !== E_HALT) begin
            n_fail++; $display("FAIL resume_cycle: got %b expected %b", obs, E_HALT);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (obs !== E_RUN) begin
            n_fail++; $display("FAIL after_resume: got %b expected %b", obs, E_RUN);
        end
        tick();
    endtask

    task automatic test_reset_mid_flush();
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (obs !== E_FLUSH) begin
            n_fail++; $display("FAIL pre_reset_flush: got %b expected %b", obs, E_FLUSH);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== E_RESET) begin
            n_fail++; $display("FAIL reset_mid_flush: got %b expected %b", obs, E_RESET);
        end
        tick();
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (obs !== E_RUN) begin
            n_fail++; $display("FAIL run_after_flush_reset: got %b expected %b", obs, E_RUN);
        end
        tick();
        // Reset during HALT, resume asserted at the same time: reset wins
        drive(0, 0, 0, 1, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (obs !== E_HALT) begin
            n_fail++; $display("FAIL pre_reset_halt: got %b expected %b", obs, E_HALT);
        end
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 1);
        n_checks++;
        if (obs !== E_RESET) begin
            n_fail++; $display("FAIL reset_mid_halt: got %b expected %b", obs, E_RESET);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (obs !== E_RUN) begin
            n_fail++; $display("FAIL run_after_halt_reset: got %b expected %b", obs, E_RUN);
        end
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        test_reset();
        test_branch();
        test_priority();
        test_stall();
        test_halt();
        test_reset_mid_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
